// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, stall codes, FSM encoding and access-size helpers for the MEM stage
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_bus_t;
  // load one-hot is {lb, lbu, lh, lhu, lw}, store one-hot is {sb, sh, sw}
  function automatic logic [1:0] f_size(input logic [4:0] ld, input logic [2:0] st);
    return (ld[0] | st[0]) ? SIZE_WORD : (ld[2] | ld[1] | st[1]) ? SIZE_HALF : SIZE_BYTE;
  endfunction
  function automatic logic f_misalign(input logic [1:0] size, input logic [1:0] addr);
    return ((size == SIZE_HALF) & addr[0]) | ((size == SIZE_WORD) & (|addr));
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a load word and sign/zero-extends it
module mem_load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [4:0]  i_load,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_data = i_load[4] ? {{24{w_byte[7]}}, w_byte} :
                  i_load[3] ? {24'd0, w_byte} :
                  i_load[2] ? {{16{w_half[15]}}, w_half} :
                  i_load[1] ? {16'd0, w_half} : i_rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage owning the data-side req/addr_ok/data_ok transaction and load alignment
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [4:0]              load_sram_ex_data,
  input  logic [2:0]              store_sram_ex_data,
  input  logic [31:0]             store_data_ex,
  output logic                    data_req,
  output logic                    data_wr,
  output logic [1:0]              data_size,
  output logic [31:0]             data_addr,
  output logic [3:0]              data_wstrb,
  output logic [31:0]             data_wdata,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic [31:0]             data_rdata,
  output logic                    stallreq_for_mem,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_bus
);
  ex_bus_t     w_in;
  ex_bus_t     r_bus;
  logic [4:0]  r_load;
  logic [2:0]  r_store;
  logic [31:0] r_rt;
  logic [31:0] r_rdata;
  state_t      r_state;
  logic        w_busy;
  logic        w_misalign;
  logic        w_we;
  logic [31:0] w_load_data;
  logic [31:0] w_wdata;
  logic        w_unused;
  assign w_in = ex_to_mem_bus;
  assign w_busy = (r_state == S_REQ) | (r_state == S_WAIT);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bus   <= '0;
      r_load  <= '0;
      r_store <= '0;
      r_rt    <= '0;
      r_rdata <= '0;
      r_state <= S_IDLE;
    end else if (!w_busy && stall[3] == STOP && stall[4] == NO_STOP) begin
      r_bus   <= '0;
      r_load  <= '0;
      r_store <= '0;
      r_rt    <= '0;
      r_state <= S_IDLE;
    end else if (!w_busy && stall[3] == NO_STOP) begin
      r_bus   <= w_in;
      r_load  <= load_sram_ex_data;
      r_store <= store_sram_ex_data;
      r_rt    <= store_data_ex;
      r_state <= (w_in.ram_en && !f_misalign(f_size(load_sram_ex_data, store_sram_ex_data),
                 w_in.result[1:0])) ? S_REQ : S_IDLE;
    end else if (r_state == S_REQ && data_addr_ok) begin
      r_state <= S_WAIT;
    end else if (r_state == S_WAIT && data_data_ok) begin
      r_state <= S_DONE;
      r_rdata <= data_rdata;
    end
  end
  assign data_req = r_state == S_REQ;
  assign data_wr = |r_store;
  assign data_size = f_size(r_load, r_store);
  assign data_addr = r_bus.result;
  assign data_wstrb = r_store[2] ? 4'b0001 << r_bus.result[1:0] :
                      r_store[1] ? (r_bus.result[1] ? 4'b1100 : 4'b0011) :
                      r_store[0] ? 4'b1111 : 4'b0000;
  assign data_wdata = r_store[2] ? {4{r_rt[7:0]}} : r_store[1] ? {2{r_rt[15:0]}} : r_rt;
  assign stallreq_for_mem = w_busy;
  mem_load_align u_align (
    .i_rdata (r_rdata),
    .i_addr  (r_bus.result[1:0]),
    .i_load  (r_load),
    .o_data  (w_load_data)
  );
  // a misaligned access never issues, so its register write is squashed
  assign w_misalign = f_misalign(data_size, r_bus.result[1:0]);
  assign w_we = r_bus.rf_we & ~w_misalign;
  assign w_wdata = r_bus.sel_rf_res ? w_load_data : r_bus.result;
  assign mem_to_wb_bus = {r_bus.pc, w_we, r_bus.rf_waddr, w_wdata};
  assign mem_to_id_bus = {w_we & ~w_busy, r_bus.rf_waddr, w_wdata};
  assign w_unused = ^{r_bus.ram_wen, stall[5], stall[2:0]};
endmodule
